// File: rtl/mag_sched_pkg.sv
// Shared types and constants for the tagged magnitude scheduler.
// Holds the fixed-point CORDIC helpers used by mag_complex.
package mag_sched_pkg;

    typedef logic signed [19:0] s20;
    typedef logic        [19:0] u20;
    typedef logic signed [23:0] s24;
    typedef logic signed [47:0] s48;

    localparam int MAG_LAT_DEF = 14;

    // Four guard bits keep CORDIC truncation well below 1 LSB.
    localparam int GB = 4;
    localparam int CW = 28;
    typedef logic signed [CW-1:0] cw_t;

    localparam int PW      = CW + 24;
    localparam int NORM_SH = 23 + GB;
    localparam s24 K_NORM  = 24'sd5094007;

    localparam logic signed [PW-1:0] RND  = PW'(1) <<< (NORM_SH - 1);
    localparam logic signed [PW-1:0] MAXM = PW'(1048575);

    function automatic cw_t abs_g(s20 v);
        cw_t e;
        e = cw_t'(v);
        if (e < 0) e = -e;
        return e <<< GB;
    endfunction

    function automatic u20 norm_mag(cw_t x);
        logic signed [PW-1:0] p;
        p = (PW'(x) * PW'(K_NORM) + RND) >>> NORM_SH;
        return (p > MAXM) ? '1 : p[19:0];
    endfunction

endpackage

// File: rtl/mag_sched_if.sv
// Request/grant and tagged-result bundle between requesters and mag_sched.
// The master side owns the I/Q requests; the slave side is the scheduler.
interface mag_sched_if #(
    parameter int N_CH = 4
);
    import mag_sched_pkg::*;

    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0] in_valid;
    logic [N_CH-1:0] in_ready;
    s20              in_i [N_CH];
    s20              in_q [N_CH];
    logic            out_valid;
    logic [CH_W-1:0] out_ch;
    u20              out_magn;

    modport master (
        output in_valid, in_i, in_q,
        input  in_ready, out_valid, out_ch, out_magn
    );

    modport slave (
        input  in_valid, in_i, in_q,
        output in_ready, out_valid, out_ch, out_magn
    );

endinterface

// File: rtl/mag_complex.sv
// Fixed-latency |I+jQ|: abs register, LAT-2 CORDIC vectoring stages,
// then gain-normalising multiply. Datapath registers carry no reset.
module mag_complex
    import mag_sched_pkg::*;
#(
    parameter int LAT = MAG_LAT_DEF
) (
    input  logic clk,
    input  s20   sig_in_i,
    input  s20   sig_in_q,
    output u20   magn
);

    localparam int NIT = LAT - 2;

    cw_t xs [NIT+1];
    cw_t ys [NIT];

    always_ff @(posedge clk) begin
        xs[0] <= abs_g(sig_in_i);
        ys[0] <= abs_g(sig_in_q);
        for (int s = 0; s < NIT; s++) begin
            // Rotate toward the x axis; x only ever grows.
            if (ys[s][CW-1]) begin
                xs[s+1] <= xs[s] - (ys[s] >>> s);
                if (s < NIT - 1)
                    ys[s+1] <= ys[s] + (xs[s] >>> s);
            end else begin
                xs[s+1] <= xs[s] + (ys[s] >>> s);
                if (s < NIT - 1)
                    ys[s+1] <= ys[s] - (xs[s] >>> s);
            end
        end
        magn <= norm_mag(xs[NIT]);
    end

endmodule

// File: rtl/mag_sched_rr_arb.sv
// Round-robin arbiter: first eligible channel strictly after ptr.
// Purely combinational; returns one-hot grant, its index and any-grant.
module mag_sched_rr_arb #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    int k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int off = 1; off <= N; off++) begin
            k = (int'(ptr) + off) % N;
            if (!any && elig[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = W'(k);
            end
        end
    end

endmodule

// File: rtl/mag_sched.sv
// Round-robin scheduler sharing one mag_complex among N_CH requesters,
// with a {vld, ch} tag line aligned to the fixed datapath latency.
module mag_sched
    import mag_sched_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int MAG_LAT = MAG_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] ch_en,
    input  logic            flush,
    mag_sched_if.slave      bus,
    output logic            busy,
    output logic [15:0]     ovf_cnt
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int DEPTH = MAG_LAT + 1;

    typedef struct packed {
        logic            vld;
        logic [CH_W-1:0] ch;
    } tag_t;

    logic [N_CH-1:0] elig;
    logic [N_CH-1:0] grant;
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] gidx;
    logic            gany;
    s20              sel_i;
    s20              sel_q;
    u20              magn;
    tag_t            tags [DEPTH];

    assign elig = bus.in_valid & ch_en & ~{N_CH{flush}};

    mag_sched_rr_arb #(.N(N_CH)) u_arb (
        .elig  (elig),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign bus.in_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= CH_W'(N_CH - 1);
            ovf_cnt <= '0;
            sel_i   <= '0;
            sel_q   <= '0;
        end else begin
            if (gany)
                ptr <= gidx;
            // Sticky debug count of requests that arrive during flush.
            if (flush && |(bus.in_valid & ch_en) && ovf_cnt != 16'hFFFF)
                ovf_cnt <= ovf_cnt + 16'd1;
            sel_i <= gany ? bus.in_i[gidx] : '0;
            sel_q <= gany ? bus.in_q[gidx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++)
                tags[k] <= '0;
        end else begin
            tags[0] <= '{vld: gany, ch: gidx};
            for (int k = 1; k < DEPTH; k++)
                tags[k] <= '{vld: tags[k-1].vld & ~flush,
                             ch:  tags[k-1].ch};
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            busy = busy | tags[k].vld;
    end

    mag_complex #(.LAT(MAG_LAT)) u_mag (
        .clk      (clk),
        .sig_in_i (sel_i),
        .sig_in_q (sel_q),
        .magn     (magn)
    );

    assign bus.out_valid = tags[DEPTH-1].vld;
    assign bus.out_ch    = tags[DEPTH-1].ch;
    assign bus.out_magn  = magn;

endmodule

// File: tb/tb_mag_sched.sv
// Self-checking bench for mag_sched: vector table, directed corners,
// and randomized traffic against a queue-based reference model.
module tb_mag_sched;
    import mag_sched_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 15;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [N-1:0]  ch_en = '0;
    logic          busy;
    logic [15:0]   ovf_cnt;

    mag_sched_if #(.N_CH(N)) bus ();

    mag_sched #(.N_CH(N), .MAG_LAT(14)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ch_en   (ch_en),
        .flush   (flush),
        .bus     (bus),
        .busy    (busy),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  due;
        int  ch;
        real mag;
    } exp_t;

    typedef struct {
        logic [N-1:0] en;
        logic [N-1:0] vld;
        logic [N-1:0] rdy;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    exp_t pend [$];
    int   last_ch = N - 1;
    int   ovf_m   = 0;
    int   cyc     = 0;
    int   gnt_m   = -1;
    int   di [N];
    int   dq [N];
    vec_t tbl [16];

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic check_mag(string nm, int act, real exp);
        real d;
        d = real'(act) - exp;
        checks++;
        if (d > 2.0 || d < -2.0) begin
            errors++;
            $display("FAIL %s: got %0d expected %f +-2 (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(int last, logic [N-1:0] elig);
        for (int off = 1; off <= N; off++) begin
            int k;
            k = (last + off) % N;
            if (elig[k]) return k;
        end
        return -1;
    endfunction

    function automatic real ref_mag(int i, int q);
        return $sqrt(real'(i) * real'(i) + real'(q) * real'(q));
    endfunction

    task automatic model_reset();
        pend.delete();
        last_ch = N - 1;
        ovf_m   = 0;
    endtask

    task automatic drive_data();
        for (int k = 0; k < N; k++) begin
            bus.in_i[k] = 20'(di[k]);
            bus.in_q[k] = 20'(dq[k]);
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic tick();
        logic [N-1:0] elig;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] one;
        exp_t         e;
        int           g;
        #1;
        one     = 1;
        elig    = bus.in_valid & ch_en & ~{N{flush}};
        g       = rr_pick(last_ch, elig);
        exp_rdy = (g >= 0) ? (one << g) : '0;
        check("in_ready", int'(bus.in_ready), int'(exp_rdy));
        check("busy", int'(busy), int'(pend.size() > 0));
        check("ovf_cnt", int'(ovf_cnt), ovf_m);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            check("out_valid", int'(bus.out_valid), 1);
            check("out_ch", int'(bus.out_ch), e.ch);
            check_mag("out_magn", int'(bus.out_magn), e.mag);
        end else begin
            check("out_valid", int'(bus.out_valid), 0);
        end
        if (flush) begin
            pend.delete();
            if (|(bus.in_valid & ch_en) && ovf_m < 65535)
                ovf_m++;
        end
        if (g >= 0) begin
            pend.push_back('{cyc + LAT, g, ref_mag(di[g], dq[g])});
            last_ch = g;
        end
        gnt_m = g;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    initial begin
        logic signed [19:0] r;

        tbl[0]  = '{4'hF, 4'hF, 4'b0001};
        tbl[1]  = '{4'hF, 4'hF, 4'b0010};
        tbl[2]  = '{4'hF, 4'hF, 4'b0100};
        tbl[3]  = '{4'hF, 4'hF, 4'b1000};
        tbl[4]  = '{4'hF, 4'hF, 4'b0001};
        tbl[5]  = '{4'hB, 4'hF, 4'b0010};
        tbl[6]  = '{4'hB, 4'hF, 4'b1000};
        tbl[7]  = '{4'hB, 4'hF, 4'b0001};
        tbl[8]  = '{4'hB, 4'h4, 4'b0000};
        tbl[9]  = '{4'hF, 4'h4, 4'b0100};
        tbl[10] = '{4'hF, 4'h4, 4'b0100};
        tbl[11] = '{4'hF, 4'h9, 4'b1000};
        tbl[12] = '{4'hF, 4'h9, 4'b0001};
        tbl[13] = '{4'h0, 4'hF, 4'b0000};
        tbl[14] = '{4'hF, 4'h0, 4'b0000};
        tbl[15] = '{4'hF, 4'h6, 4'b0010};

        di = '{100, -524288, 1000, -3000};
        dq = '{200, -524288, 0, 4000};
        bus.in_valid = '0;
        drive_data();

        // Reset state
        #12;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_ch", int'(bus.out_ch), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_ovf", int'(ovf_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Single grant on ch2, exact latency
        ch_en        = 4'hF;
        bus.in_valid = 4'b0100;
        #1 check("t1_ready", int'(bus.in_ready), 4);
        tick();
        bus.in_valid = '0;
        idle(14);
        #1;
        check("t1_lat_valid", int'(bus.out_valid), 1);
        check("t1_lat_ch", int'(bus.out_ch), 2);
        check_mag("t1_lat_magn", int'(bus.out_magn), 1000.0);
        tick();
        idle(2);

        // Async reset pulse between edges
        #3 rst_n = 1'b0;
        #1 model_reset();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;

        // Vector table: arbitration order, masking, back-to-back
        for (int i = 0; i < 16; i++) begin
            ch_en        = tbl[i].en;
            bus.in_valid = tbl[i].vld;
            #1 check($sformatf("tbl%0d_ready", i),
                     int'(bus.in_ready), int'(tbl[i].rdy));
            tick();
        end
        bus.in_valid = '0;
        ch_en        = 4'hF;
        idle(17);

        // Flush with six grants in flight
        bus.in_valid = 4'hF;
        idle(6);
        bus.in_valid = '0;
        flush        = 1'b1;
        tick();
        flush = 1'b0;
        #1 check("t4_busy", int'(busy), 0);
        check("t4_ovf", int'(ovf_cnt), 0);
        idle(18);
        bus.in_valid = 4'hF;
        flush        = 1'b1;
        idle(2);
        flush        = 1'b0;
        bus.in_valid = '0;
        #1 check("t4_ovf_cnt2", int'(ovf_cnt), 2);
        tick();

        // Mid-stream async reset
        bus.in_valid = 4'hF;
        idle(5);
        #3 rst_n = 1'b0;
        #1;
        check("t5_out_valid", int'(bus.out_valid), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_ovf", int'(ovf_cnt), 0);
        model_reset();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        #1 check("t5_first", int'(bus.in_ready), 1);
        tick();
        bus.in_valid = '0;
        idle(16);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0)
                ch_en = 4'($urandom_range(0, 15));
            flush = ($urandom_range(0, 31) == 0);
            for (int k = 0; k < N; k++) begin
                if (!bus.in_valid[k] && $urandom_range(0, 1) == 1) begin
                    r     = 20'($urandom());
                    di[k] = int'(r);
                    r     = 20'($urandom());
                    dq[k] = int'(r);
                    bus.in_valid[k] = 1'b1;
                end
            end
            drive_data();
            tick();
            if (gnt_m >= 0)
                bus.in_valid[gnt_m] = 1'b0;
        end
        flush        = 1'b0;
        bus.in_valid = '0;
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
